bcd_serial_add_ctrl: RTL



---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_add_ci.sv | 25 ++
 rtl/bcd_serial_add_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the serial BCD adder controller.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return BCD_MAX - digit;
  endfunction

  function automatic logic digit_valid(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add_ci.sv
// Combinational single-digit decimal adder with carry in/out.
module bcd_digit_add_ci
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] r,
  output logic       cout
);

  logic [4:0] s;

  assign s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

  always_comb begin
    r    = s[3:0];
    cout = 1'b0;
    if (s > {1'b0, BCD_MAX}) begin
      r    = 4'(s - 5'd10);
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD add sequencer, LSD first, one digit per clock.
// BCD_SUBTRACT_EN adds a `sub` input for nines'-complement subtraction.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int CNT_W  = $clog2(DIGITS) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef BCD_SUBTRACT_EN
  input  logic                sub,
`endif
  input  logic [4*DIGITS-1:0] a_bcd,
  input  logic [4*DIGITS-1:0] b_bcd,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum_bcd,
  output logic                carry_out,
  output logic                err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

  state_t              state_reg, state_next;
  logic [4*DIGITS-1:0] a_reg, b_reg, sum_reg;
  logic [CNT_W-1:0]    idx_reg;
  logic                carry_reg, carry_out_reg, err_reg;
`ifdef BCD_SUBTRACT_EN
  logic                sub_reg;
`endif

  logic [3:0]          a_dig, b_dig, b_eff, add_r;
  logic                add_cout;
  logic [2*DIGITS-1:0] digit_bad;

  // One flag per operand digit; any set flag aborts the operation with err.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
      assign digit_bad[2*gi]   = !digit_valid(a_reg[4*gi +: 4]);
      assign digit_bad[2*gi+1] = !digit_valid(b_reg[4*gi +: 4]);
    end
  endgenerate

  assign a_dig = a_reg[4*idx_reg +: 4];
  assign b_dig = b_reg[4*idx_reg +: 4];

`ifdef BCD_SUBTRACT_EN
  assign b_eff = sub_reg ? nines_comp(b_dig) : b_dig;
`else
  assign b_eff = b_dig;
`endif

  bcd_digit_add_ci u_digit_add (
    .a    (a_dig),
    .b    (b_eff),
    .cin  (carry_reg),
    .r    (add_r),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = (|digit_bad) ? DONE : ADD;
      ADD:     if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      err_reg       <= 1'b0;
`ifdef BCD_SUBTRACT_EN
      sub_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg   <= a_bcd;
            b_reg   <= b_bcd;
            idx_reg <= '0;
`ifdef BCD_SUBTRACT_EN
            // Ten's complement of B = nines' complement plus an initial carry.
            sub_reg   <= sub;
            carry_reg <= sub;
`else
            carry_reg <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (|digit_bad) begin
            err_reg       <= 1'b1;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
          end else begin
            err_reg <= 1'b0;
          end
        end
        ADD: begin
          sum_reg[4*idx_reg +: 4] <= add_r;
          carry_reg               <= add_cout;
          idx_reg                 <= idx_reg + CNT_W'(1);
          if (idx_reg == LAST_IDX) carry_out_reg <= add_cout;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign sum_bcd   = sum_reg;
  assign carry_out = carry_out_reg;
  assign err       = err_reg;

endmodule
